// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU function
// codes, state codes (also visible on the debug step port), opcode classes and
// the strobe bundle passed from the decoder to the top.
// Build option: MUL_DIV_EN -- when defined, mul/div are decoded; otherwise they
// fall into the nop class and ALU_MUL/ALU_DIV are never issued.
package control_sequencer_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_NOT = 4'd6;
   localparam logic [3:0] ALU_NEG = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_DIV = 4'd9;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_T7   = 4'd8,
      ST_HALT = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP,
      CLS_RFMT,
      CLS_IMM,
      CLS_UNARY,
      CLS_LDI,
      CLS_LD,
      CLS_ST,
      CLS_MULDIV,
      CLS_HALT
   } op_class_t;

   typedef struct packed {
      logic       pc_out;
      logic       pc_in;
      logic       inc_pc;
      logic       mar_in;
      logic       mdr_in;
      logic       mdr_out;
      logic       rd;
      logic       wr;
      logic       ir_in;
      logic       y_in;
      logic       zhi_in;
      logic       zlo_in;
      logic       zhigh_out;
      logic       zlow_out;
      logic       hi_in;
      logic       lo_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic       c_out;
      logic       done;
      logic       halted;
      logic [3:0] alu_op;
   } ctrl_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      op_class_t c;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: c = CLS_RFMT;
         OP_ADDI, OP_ANDI, OP_ORI:                      c = CLS_IMM;
         OP_NEG, OP_NOT:                                c = CLS_UNARY;
         OP_LDI:                                        c = CLS_LDI;
         OP_LD:                                         c = CLS_LD;
         OP_ST:                                         c = CLS_ST;
         OP_HALT:                                       c = CLS_HALT;
`ifdef MUL_DIV_EN
         OP_MUL, OP_DIV:                                c = CLS_MULDIV;
`endif
         default:                                       c = CLS_NOP;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] op_alu(input logic [4:0] op);
      logic [3:0] a;
      case (op)
         OP_SUB:          a = ALU_SUB;
         OP_AND, OP_ANDI: a = ALU_AND;
         OP_OR,  OP_ORI:  a = ALU_OR;
         OP_SHR:          a = ALU_SHR;
         OP_SHL:          a = ALU_SHL;
         OP_NEG:          a = ALU_NEG;
         OP_NOT:          a = ALU_NOT;
`ifdef MUL_DIV_EN
         OP_MUL:          a = ALU_MUL;
         OP_DIV:          a = ALU_DIV;
`endif
         default:         a = ALU_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// control_decode: purely combinational (state, opcode) -> strobe bundle.
// Ports: state_i current step, opcode_i IR[31:27], mem_ready_i (only used for
// the st write step, whose Done coincides with memory completion),
// t1_first_i high in the first T1 cycle (PCin is a one-shot), ctrl_o strobes.
// Build option: MUL_DIV_EN (via op_class in the package).
module control_decode
   import control_sequencer_pkg::*;
(
   input  state_t     state_i,
   input  logic [4:0] opcode_i,
   input  logic       mem_ready_i,
   input  logic       t1_first_i,
   output ctrl_t      ctrl_o
);

   op_class_t cls;
   logic [3:0] alu;

   assign cls = op_class(opcode_i);
   assign alu = op_alu(opcode_i);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_T0: begin
            ctrl_o.pc_out = 1'b1;
            ctrl_o.mar_in = 1'b1;
            ctrl_o.inc_pc = 1'b1;
            ctrl_o.zlo_in = 1'b1;
            ctrl_o.alu_op = ALU_ADD;
         end
         ST_T1: begin
            ctrl_o.zlow_out = 1'b1;
            ctrl_o.pc_in    = t1_first_i;
            ctrl_o.rd       = 1'b1;
            ctrl_o.mdr_in   = 1'b1;
         end
         ST_T2: begin
            ctrl_o.mdr_out = 1'b1;
            ctrl_o.ir_in   = 1'b1;
         end
         ST_T3: begin
            case (cls)
               CLS_RFMT, CLS_IMM: begin
                  ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1;
               end
               CLS_UNARY: begin
                  ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1;
                  ctrl_o.zlo_in = 1'b1; ctrl_o.alu_op = alu;
               end
               CLS_LDI, CLS_LD, CLS_ST: begin
                  ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_in = 1'b1;
               end
               CLS_MULDIV: begin
                  ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1;
               end
               CLS_NOP: ctrl_o.done = 1'b1;
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CLS_RFMT: begin
                  ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1;
                  ctrl_o.zlo_in = 1'b1; ctrl_o.alu_op = alu;
               end
               CLS_IMM: begin
                  ctrl_o.c_out = 1'b1; ctrl_o.zlo_in = 1'b1; ctrl_o.alu_op = alu;
               end
               CLS_UNARY: begin
                  ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1;
                  ctrl_o.r_in = 1'b1; ctrl_o.done = 1'b1;
               end
               CLS_LDI, CLS_LD, CLS_ST: begin
                  ctrl_o.c_out = 1'b1; ctrl_o.zlo_in = 1'b1; ctrl_o.alu_op = ALU_ADD;
               end
               CLS_MULDIV: begin
                  ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.zhi_in = 1'b1;
                  ctrl_o.zlo_in = 1'b1; ctrl_o.alu_op = alu;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (cls)
               CLS_RFMT, CLS_IMM, CLS_LDI: begin
                  ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1;
                  ctrl_o.r_in = 1'b1; ctrl_o.done = 1'b1;
               end
               CLS_LD, CLS_ST: begin
                  ctrl_o.zlow_out = 1'b1; ctrl_o.mar_in = 1'b1;
               end
               CLS_MULDIV: begin
                  ctrl_o.zlow_out = 1'b1; ctrl_o.lo_in = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (cls)
               CLS_LD: begin
                  ctrl_o.rd = 1'b1; ctrl_o.mdr_in = 1'b1;
               end
               CLS_ST: begin
                  ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.mdr_in = 1'b1;
               end
               CLS_MULDIV: begin
                  ctrl_o.zhigh_out = 1'b1; ctrl_o.hi_in = 1'b1; ctrl_o.done = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (cls)
               CLS_LD: begin
                  ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1;
                  ctrl_o.r_in = 1'b1; ctrl_o.done = 1'b1;
               end
               CLS_ST: begin
                  ctrl_o.wr   = 1'b1;
                  ctrl_o.done = mem_ready_i;
               end
               default: ;
            endcase
         end
         ST_HALT: ctrl_o.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0..T7 control-step sequencer for the
// register-transfer datapath. Holds the state register and next-state logic;
// strobes come from control_decode.
// Inputs: Clock, Clear (sync, active-high), Run, IR[31:0], MemReady.
// Outputs: PC/memory/special-register/register-select strobes, alu_op[3:0],
// Done (final-step pulse), Halted, step[3:0] (state code, debug).
// Build option: MUL_DIV_EN enables mul/div execution.
//
// state | meaning
// IDLE  | waiting for Run, all strobes low
// T0    | PC -> MAR, PC+1 -> Z
// T1    | read instruction, Z -> PC on first cycle; waits on MemReady
// T2    | MDR -> IR
// T3-T7 | execute steps, per opcode class
// HALT  | Halted high, left only by Clear
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic        Clock,
   input  logic        Clear,
   input  logic        Run,
   input  logic [31:0] IR,
   input  logic        MemReady,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        Write,
   output logic        IRin,
   output logic        Yin,
   output logic        ZHIin,
   output logic        ZLOin,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIin,
   output logic        LOin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic [3:0]  alu_op,
   output logic        Done,
   output logic        Halted,
   output logic [3:0]  step
);

   state_t     state_q, state_d;
   logic       t1_wait_q, t1_wait_d;
   logic [4:0] opcode;
   op_class_t  cls;
   ctrl_t      ctrl;
   logic       unused_ir;

   assign opcode    = IR[31:27];
   assign cls       = op_class(opcode);
   assign unused_ir = ^IR[26:0];

   // Set after any T1 cycle that stays in T1, so PCin fires only once.
   assign t1_wait_d = (state_q == ST_T1) && (state_d == ST_T1);

   control_decode u_decode (
      .state_i     (state_q),
      .opcode_i    (opcode),
      .mem_ready_i (MemReady),
      .t1_first_i  (~t1_wait_q),
      .ctrl_o      (ctrl)
   );

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q   <= ST_IDLE;
         t1_wait_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         t1_wait_q <= t1_wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (Run) state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1:   if (MemReady) state_d = ST_T2;
         ST_T2:   state_d = ST_T3;
         ST_T3:   state_d = (cls == CLS_HALT) ? ST_HALT : ST_T4;
         ST_T4:   state_d = ST_T5;
         ST_T5:   state_d = ST_T6;
         ST_T6:   if (!(cls == CLS_LD && !MemReady)) state_d = ST_T7;
         ST_T7:   state_d = ST_T7;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
      // The Done step ends every instruction regardless of where it falls;
      // st at T7 only raises Done once memory accepts the write.
      if (ctrl.done) state_d = Run ? ST_T0 : ST_IDLE;
   end

   always_comb begin
      PCout    = ctrl.pc_out;
      PCin     = ctrl.pc_in;
      IncPC    = ctrl.inc_pc;
      MARin    = ctrl.mar_in;
      MDRin    = ctrl.mdr_in;
      MDRout   = ctrl.mdr_out;
      Read     = ctrl.rd;
      Write    = ctrl.wr;
      IRin     = ctrl.ir_in;
      Yin      = ctrl.y_in;
      ZHIin    = ctrl.zhi_in;
      ZLOin    = ctrl.zlo_in;
      Zhighout = ctrl.zhigh_out;
      Zlowout  = ctrl.zlow_out;
      HIin     = ctrl.hi_in;
      LOin     = ctrl.lo_in;
      Gra      = ctrl.gra;
      Grb      = ctrl.grb;
      Grc      = ctrl.grc;
      Rin      = ctrl.r_in;
      Rout     = ctrl.r_out;
      BAout    = ctrl.ba_out;
      Cout     = ctrl.c_out;
      alu_op   = ctrl.alu_op;
      Done     = ctrl.done;
      Halted   = ctrl.halted;
      step     = state_q;
   end

endmodule
